tictactoe_move_engine: RTL and testbench
========================================

# tictactoe_move_engine

Move-processing core of the tic-tac-toe game. Accepts one move request at a time from the input front end (switch position plus strobe), validates it and writes the current player's mark into the board register. It then evaluates the eight winning lines and the draw condition, and either hands the turn to the other player or ends the game. It owns the board, player, winner and game-over state that the display path reads; the asynchronous reset returns everything to a fresh game.

## Interface
- No parameters. Board size is fixed at 3x3.
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; returns block to fresh-game state
- move_valid  input  1  move request strobe; sampled only when move_ready=1
- move_pos  input  4  requested cell, 0..8 row-major (0=top-left, 8=bottom-right)
- move_ready  output  1  high when a move can be accepted
- move_ack  output  1  one-cycle pulse: accepted move has been evaluated
- move_err  output  1  one-cycle pulse: request rejected (out of range or occupied)
- board  output  18  cell i in board[2i+1:2i]; 00 empty, 01 X, 10 O
- current_player  output  2  01 X, 10 O; player whose move is expected
- winner  output  2  00 none, 01 X, 10 O
- draw  output  1  board full with no winner
- game_over  output  1  winner or draw reached

## Operation
- States: IDLE (move_ready=1), CHECK (evaluate last move), OVER (terminal).
- IDLE, move_valid=1:
  - If move_pos>8, or the addressed cell is non-zero: move_err=1 for the next cycle, board and player unchanged, remain IDLE.
  - Otherwise: write current_player into the cell, go to CHECK.
- IDLE, move_valid=0: hold.
- CHECK: evaluate the registered board for current_player on the lines {0,1,2} {3,4,5} {6,7,8} {0,3,6} {1,4,7} {2,5,8} {0,4,8} {2,4,6}.
  - Win: winner<=current_player, game_over<=1, go to OVER.
  - Else, all 9 cells non-zero: draw<=1, game_over<=1, go to OVER.
  - Else: current_player toggles 01<->10, go to IDLE.
  - In all three cases move_ack=1 for exactly one cycle.
  - A win on the 9th move takes priority over draw: winner set, draw stays 0.
- OVER: move_ready=0. move_valid is ignored, with no move_err. All outputs hold. Only reset leaves OVER.
- current_player does not toggle on the finishing move.
- move_valid in CHECK or OVER is dropped, not queued.

## Timing
- Reset values (async, immediate): board=0, current_player=01, winner=00, draw=0, game_over=0, move_ready=1, move_ack=0, move_err=0, state IDLE.
- Accepted move sampled at edge N:
  - Board cell updated and move_ready=0 from edge N.
  - At edge N+1: move_ack=1, and winner/draw/game_over/current_player take their new values.
  - move_ready=1 again after N+1 unless the game is over.
  - Minimum spacing between accepted moves: 2 cycles.
- Rejected move sampled at edge N: move_err=1 from N to N+1; move_ready stays 1.
- move_ack and move_err are never high in the same cycle.
- Reset asserted in any state, including CHECK: all outputs take reset values at once; any pending evaluation is discarded.
- move_valid held high for several cycles is treated as one request per IDLE cycle. The front end is responsible for delivering single-cycle strobes.

## Test plan
- X wins top row: after reset, moves 0,3,1,4,2 -> winner=01, game_over=1, draw=0, board=18'h00015 | (2'b10<<6) | (2'b10<<8), current_player stays 01, move_ready=0.
- Draw: moves 0,1,2,4,3,5,7,6,8 -> draw=1, game_over=1, winner=00, nine move_acks, no move_err.
- Illegal moves: move 4 by X, then O requests 4 -> move_err pulse, board unchanged, current_player=10. O requests 9 -> move_err; O requests 8 -> accepted, move_ack.
- O wins diagonal {2,4,6}: moves 0,2,1,4,5,6 -> winner=10 on the 6th move's ack; a further move_valid to pos 3 yields neither ack nor err.
- Back-to-back strobe: move_valid high in the CHECK cycle -> ignored, only one cell written.
- Reset mid-operation: reset asserted during CHECK after the 3rd move -> board=0, current_player=01, move_ready=1. Next move 8 is accepted as X.

Source files
------------

// File: rtl/tictactoe_move_engine.sv
// Tic-tac-toe move engine: validates one move per request, writes the mark,
// then evaluates win/draw on the following cycle and passes the turn or ends the game.
module tictactoe_move_engine (
   input  logic        clk,
   input  logic        reset,
   input  logic        move_valid,
   input  logic [3:0]  move_pos,
   output logic        move_ready,
   output logic        move_ack,
   output logic        move_err,
   output logic [17:0] board,
   output logic [1:0]  current_player,
   output logic [1:0]  winner,
   output logic        draw,
   output logic        game_over
);

   typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

   // One 9-bit cell mask per winning line, bit i = cell i.
   localparam logic [7:0][8:0] WIN_MASK = {
      9'h054, 9'h111, 9'h124, 9'h092,
      9'h049, 9'h1C0, 9'h038, 9'h007
   };

   state_t      state, state_nx;
   logic [17:0] board_nx;
   logic [1:0]  player_nx, winner_nx;
   logic        draw_nx, over_nx, ack_nx, err_nx;

   logic [1:0]  target;
   logic [8:0]  mine, occ;
   logic        win, full;

   always_comb begin
      target = 2'b00;
      mine   = '0;
      occ    = '0;
      win    = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (move_pos == 4'(i)) target = board[2*i +: 2];
         mine[i] = (board[2*i +: 2] == current_player);
         occ[i]  = |board[2*i +: 2];
      end
      for (int l = 0; l < 8; l++)
         if ((mine & WIN_MASK[l]) == WIN_MASK[l]) win = 1'b1;
      full = &occ;
   end

   always_comb begin
      state_nx   = state;
      board_nx   = board;
      player_nx  = current_player;
      winner_nx  = winner;
      draw_nx    = draw;
      over_nx    = game_over;
      ack_nx     = 1'b0;
      err_nx     = 1'b0;
      move_ready = (state == IDLE);
      case (state)
         IDLE: begin
            if (move_valid) begin
               if (move_pos > 4'd8 || target != 2'b00) begin
                  err_nx = 1'b1;
               end else begin
                  for (int i = 0; i < 9; i++)
                     if (move_pos == 4'(i)) board_nx[2*i +: 2] = current_player;
                  state_nx = CHECK;
               end
            end
         end
         CHECK: begin
            ack_nx = 1'b1;
            // Win is tested before full so a ninth-move win is not a draw.
            if (win) begin
               winner_nx = current_player;
               over_nx   = 1'b1;
               state_nx  = OVER;
            end else if (full) begin
               draw_nx  = 1'b1;
               over_nx  = 1'b1;
               state_nx = OVER;
            end else begin
               player_nx = ~current_player;
               state_nx  = IDLE;
            end
         end
         OVER:    state_nx = OVER;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         board          <= '0;
         current_player <= 2'b01;
         winner         <= 2'b00;
         draw           <= 1'b0;
         game_over      <= 1'b0;
         move_ack       <= 1'b0;
         move_err       <= 1'b0;
      end else begin
         state          <= state_nx;
         board          <= board_nx;
         current_player <= player_nx;
         winner         <= winner_nx;
         draw           <= draw_nx;
         game_over      <= over_nx;
         move_ack       <= ack_nx;
         move_err       <= err_nx;
      end
   end

endmodule

// File: tb/tb_tictactoe_move_engine.sv
// Bench for tictactoe_move_engine: game-level reference model compared every
// cycle, directed game scenarios with literal expectations, then random play.
module tb_tictactoe_move_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        move_valid = 1'b0;
   logic [3:0]  move_pos = '0;
   logic        move_ready, move_ack, move_err;
   logic [17:0] board;
   logic [1:0]  current_player, winner;
   logic        draw, game_over;

   int errors = 0;
   int checks = 0;
   int ack_cnt = 0;
   int err_cnt = 0;

   tictactoe_move_engine dut (
      .clk(clk), .reset(reset), .move_valid(move_valid), .move_pos(move_pos),
      .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
      .board(board), .current_player(current_player), .winner(winner),
      .draw(draw), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Reference model: the game as cells, whose turn, and whether a placed
   // mark is still waiting to be judged.
   int  cells [9];
   int  player, m_winner;
   bit  m_draw, m_over, pending, e_ack, e_err;
   int  lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic bit has_line(int p);
      for (int l = 0; l < 8; l++)
         if (cells[lines[l][0]] == p && cells[lines[l][1]] == p && cells[lines[l][2]] == p)
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit is_full();
      for (int i = 0; i < 9; i++) if (cells[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 9; i++) cells[i] = 0;
      player = 1; m_winner = 0; m_draw = 0; m_over = 0;
      pending = 0; e_ack = 0; e_err = 0;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         e_ack = 0;
         e_err = 0;
         if (pending) begin
            e_ack = 1;
            pending = 0;
            if (has_line(player)) begin
               m_winner = player; m_over = 1;
            end else if (is_full()) begin
               m_draw = 1; m_over = 1;
            end else begin
               player = 3 - player;
            end
         end else if (!m_over && move_valid) begin
            if (move_pos > 8 || cells[move_pos] != 0) e_err = 1;
            else begin
               cells[move_pos] = player;
               pending = 1;
            end
         end
      end
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_all();
      logic [17:0] eb;
      eb = '0;
      for (int i = 0; i < 9; i++) eb[2*i +: 2] = 2'(cells[i]);
      chk("board", 32'(board), 32'(eb));
      chk("player", 32'(current_player), 32'(player));
      chk("winner", 32'(winner), 32'(m_winner));
      chk("draw", 32'(draw), 32'(m_draw));
      chk("game_over", 32'(game_over), 32'(m_over));
      chk("move_ready", 32'(move_ready), 32'(!pending && !m_over));
      chk("move_ack", 32'(move_ack), 32'(e_ack));
      chk("move_err", 32'(move_err), 32'(e_err));
   endfunction

   always @(negedge clk) begin
      check_all();
      if (move_ack) ack_cnt++;
      if (move_err) err_cnt++;
   end

   task automatic do_reset();
      @(negedge clk); #1;
      reset = 1'b1; move_valid = 1'b0;
      m_reset();
      #1;
      check_all();
      @(negedge clk); #1;
      reset = 1'b0;
      ack_cnt = 0; err_cnt = 0;
   endtask

   // One-cycle strobe, then wait until its evaluation (or rejection) is done.
   task automatic do_move(int pos);
      move_valid = 1'b1; move_pos = 4'(pos);
      @(negedge clk); #1;
      move_valid = 1'b0;
      @(negedge clk); #1;
   endtask

   initial begin
      int seq_x[5]  = '{0,3,1,4,2};
      int seq_d[9]  = '{0,1,2,4,3,5,7,6,8};
      int seq_o[6]  = '{0,2,1,4,5,6};
      m_reset();
      reset = 1'b1;
      #2;
      chk("reset_board", 32'(board), 32'h0);
      chk("reset_player", 32'(current_player), 32'h1);
      chk("reset_ready", 32'(move_ready), 32'h1);
      reset = 1'b0;

      // X wins the top row
      do_reset();
      foreach (seq_x[i]) do_move(seq_x[i]);
      chk("xwin_winner", 32'(winner), 32'h1);
      chk("xwin_over", 32'(game_over), 32'h1);
      chk("xwin_draw", 32'(draw), 32'h0);
      chk("xwin_board", 32'(board), 32'h00295);
      chk("xwin_player", 32'(current_player), 32'h1);
      chk("xwin_ready", 32'(move_ready), 32'h0);

      // Draw
      do_reset();
      foreach (seq_d[i]) do_move(seq_d[i]);
      chk("draw_draw", 32'(draw), 32'h1);
      chk("draw_winner", 32'(winner), 32'h0);
      chk("draw_acks", 32'(ack_cnt), 32'd9);
      chk("draw_errs", 32'(err_cnt), 32'd0);

      // Illegal moves: occupied, out of range, then a legal one
      do_reset();
      do_move(4);
      do_move(4);
      chk("occ_err", 32'(err_cnt), 32'd1);
      chk("occ_board", 32'(board), 32'h00100);
      chk("occ_player", 32'(current_player), 32'h2);
      do_move(9);
      chk("range_err", 32'(err_cnt), 32'd2);
      do_move(8);
      chk("legal_ack", 32'(ack_cnt), 32'd2);
      chk("legal_board", 32'(board), 32'h20100);

      // O wins on the {2,4,6} diagonal; a later request is dropped silently
      do_reset();
      foreach (seq_o[i]) do_move(seq_o[i]);
      chk("owin_winner", 32'(winner), 32'h2);
      do_move(3);
      chk("over_acks", 32'(ack_cnt), 32'd6);
      chk("over_errs", 32'(err_cnt), 32'd0);

      // Strobe still high during the evaluation cycle writes only one cell
      do_reset();
      move_valid = 1'b1; move_pos = 4'd0;
      @(negedge clk); #1;
      move_pos = 4'd1;
      @(negedge clk); #1;
      move_valid = 1'b0;
      @(negedge clk); #1;
      chk("b2b_board", 32'(board), 32'h1);

      // Reset during the evaluation of the third move
      do_reset();
      do_move(0);
      do_move(1);
      move_valid = 1'b1; move_pos = 4'd2;
      @(negedge clk); #1;
      move_valid = 1'b0;
      reset = 1'b1;
      m_reset();
      #1;
      chk("midrst_board", 32'(board), 32'h0);
      chk("midrst_player", 32'(current_player), 32'h1);
      chk("midrst_ready", 32'(move_ready), 32'h1);
      @(negedge clk); #1;
      reset = 1'b0;
      do_move(8);
      chk("midrst_next", 32'(board), 32'h10000);

      // Random play with occasional resets
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk); #1;
         if ($urandom_range(0, 99) < 2) begin
            reset = 1'b1;
            move_valid = 1'b0;
            m_reset();
         end else begin
            reset = 1'b0;
            move_valid = ($urandom_range(0, 2) != 0);
            move_pos = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                                   : 4'($urandom_range(0, 8));
         end
      end
      @(negedge clk); #1;
      reset = 1'b0; move_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
